uart_rx_core: RTL and testbench

// - 8N1 UART receiver for the MCU serial port. It is the receiving end of the

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_core.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divider helper.
// The transmitter imports this package as well.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_e;

    // Clocks per oversample tick, truncated toward zero.
    function automatic int baud_div(input int clk_freq, input int baud, input int ovs);
        return clk_freq / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running tick generator: one-cycle pulse every DIV clocks, restartable via clear.
// Shared with the transmitter, which instantiates it at one tick per bit.
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 oversampling UART receiver with start-glitch rejection, a one-entry
// valid/ready holding register, and framing-error / overrun pulses.
module uart_rx_core #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    import uart_pkg::*;

    localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    uart_rx_state_e state;
    uart_rx_state_e state_next;

    logic [TW-1:0]        tick_cnt;
    logic [TW-1:0]        tick_cnt_next;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [DATA_BITS:0]   shift_in;

    logic tick;
    logic baud_clear;
    logic complete;
    logic bad_stop;
    logic handshake;

    // Synchronizer plus edge-detect flop; all reset to the idle (high) level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_cnt_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
        end
    end

    assign shift_in = {rx_sync, shift_reg};

    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift_reg;
        baud_clear    = 1'b0;
        complete      = 1'b0;
        bad_stop      = 1'b0;

        case (state)
            IDLE: begin
                // Edge-triggered so a held-low line (break) cannot restart a frame.
                if (rx_prev && !rx_sync) begin
                    state_next    = START;
                    tick_cnt_next = '0;
                    bit_cnt_next  = '0;
                    baud_clear    = 1'b1;
                end
            end

            START: begin
                if (tick) begin
                    if (tick_cnt == HALF_LAST) begin
                        tick_cnt_next = '0;
                        state_next    = rx_sync ? IDLE : DATA;
                    end else begin
                        tick_cnt_next = tick_cnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_cnt_next = '0;
                        shift_next    = shift_in[DATA_BITS:1];
                        bit_cnt_next  = bit_cnt + 1'b1;
                        if (bit_cnt == BITS_LAST) begin
                            state_next = STOP;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt + 1'b1;
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_cnt_next = '0;
                        state_next    = IDLE;
                        complete      = rx_sync;
                        bad_stop      = !rx_sync;
                    end else begin
                        tick_cnt_next = tick_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign handshake = rx_valid && rx_ready;

    // A completion may refill the register in the same cycle it is drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            overrun   <= complete && rx_valid && !rx_ready;
            if (complete && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (handshake && !complete) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: table vectors, corner-case sequences,
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx_core;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int OVS      = 16;
    localparam int BIT      = 16;
    localparam int LAT      = 155;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    uart_rx_core #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (OVS),
        .DATA_BITS  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         c;
    } ev_t;

    ev_t got_q[$];
    int  fe_q[$];
    int  ov_q[$];

    // Log accepted bytes and error pulses with the cycle they were seen in.
    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            if (rx_valid && rx_ready) begin
                e.d = rx_data;
                e.c = cyc;
                got_q.push_back(e);
            end
            if (frame_err) fe_q.push_back(cyc);
            if (overrun) ov_q.push_back(cyc);
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       stop_bit;
        int         gap;
        logic       exp_valid;
        logic       exp_fe;
    } vec_t;

    vec_t       vecs[6];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] last_good;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        got_q.delete();
        fe_q.delete();
        ov_q.delete();
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int start);
        start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    // Expected result of one frame with the consumer always ready.
    task automatic check_frame(input string name, input logic [7:0] d, input logic exp_valid,
                               input logic exp_fe, input int start);
        if (exp_valid) begin
            check_output({name, " valid count"}, got_q.size(), 1);
            if (got_q.size() > 0) begin
                check_output({name, " data"}, got_q[0].d, d);
                check_output({name, " valid cycle"}, got_q[0].c, start + LAT);
            end
            last_good = d;
        end else begin
            check_output({name, " valid count"}, got_q.size(), 0);
            check_output({name, " held data"}, rx_data, last_good);
        end
        check_output({name, " frame_err count"}, fe_q.size(), exp_fe ? 1 : 0);
        if (exp_fe && fe_q.size() > 0) begin
            check_output({name, " frame_err cycle"}, fe_q[0], start + LAT);
        end
        check_output({name, " overrun count"}, ov_q.size(), 0);
        clear_logs();
    endtask

    task automatic apply_stimulus(input string name, input vec_t v);
        int start;
        send_frame(v.d, v.stop_bit, start);
        check_frame(name, v.d, v.exp_valid, v.exp_fe, start);
        idle(v.gap);
    endtask

    initial begin
        int s1;
        int s2;
        vec_t rv;

        vecs[0] = '{8'h55, 1'b1, 20, 1'b1, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 20, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1,  0, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1,  0, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 20, 1'b1, 1'b0};
        vecs[5] = '{8'h01, 1'b1,  5, 1'b1, 1'b0};

        reset     = 1'b1;
        rx        = 1'b1;
        rx_ready  = 1'b0;
        last_good = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset rx_valid", rx_valid, 0);
        check_output("reset rx_data", rx_data, 0);
        check_output("reset frame_err", frame_err, 0);
        check_output("reset overrun", overrun, 0);
        reset = 1'b0;
        rx_ready = 1'b1;
        idle(10);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Three-tick low glitch must be rejected, then a normal frame follows.
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(200);
        check_output("glitch valid count", got_q.size(), 0);
        check_output("glitch frame_err count", fe_q.size(), 0);
        check_output("glitch rx_valid", rx_valid, 0);
        clear_logs();
        send_frame(8'h5A, 1'b1, s1);
        check_frame("after glitch", 8'h5A, 1'b1, 1'b0, s1);
        idle(10);

        $display("[TB] overrun sequence");
        rx_ready = 1'b0;
        send_frame(8'h12, 1'b1, s1);
        check_output("ovr first valid", rx_valid, 1);
        check_output("ovr first data", rx_data, 8'h12);
        send_frame(8'h34, 1'b1, s2);
        check_output("ovr pulse count", ov_q.size(), 1);
        if (ov_q.size() > 0) check_output("ovr pulse cycle", ov_q[0], s2 + LAT);
        check_output("ovr held data", rx_data, 8'h12);
        check_output("ovr no frame_err", fe_q.size(), 0);
        clear_logs();
        rx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("ovr drain count", got_q.size(), 1);
        if (got_q.size() > 0) check_output("ovr drain data", got_q[0].d, 8'h12);
        check_output("ovr drained valid", rx_valid, 0);
        clear_logs();
        idle(10);

        $display("[TB] handshake coinciding with completion");
        rx_ready = 1'b0;
        send_frame(8'h3C, 1'b1, s1);
        fork
            send_frame(8'hC5, 1'b1, s2);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1;
                rx_ready = 1'b1;
            end
        join
        check_output("same-cycle count", got_q.size(), 2);
        if (got_q.size() > 1) begin
            check_output("same-cycle old data", got_q[0].d, 8'h3C);
            check_output("same-cycle new data", got_q[1].d, 8'hC5);
            check_output("same-cycle new cycle", got_q[1].c, s2 + LAT);
        end
        check_output("same-cycle overrun", ov_q.size(), 0);
        clear_logs();
        last_good = 8'hC5;
        idle(10);

        $display("[TB] reset during data");
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        reset = 1'b1;
        #1;
        check_output("midreset rx_valid", rx_valid, 0);
        check_output("midreset rx_data", rx_data, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        last_good = 8'h00;
        clear_logs();
        idle(20);
        send_frame(8'hC3, 1'b1, s1);
        check_frame("after reset", 8'hC3, 1'b1, 1'b0, s1);
        idle(10);

        $display("[TB] randomized frames");
        for (int i = 0; i < 20; i++) begin
            rv.d         = 8'($urandom);
            rv.stop_bit  = ($urandom_range(0, 3) != 0);
            rv.gap       = rv.stop_bit ? $urandom_range(0, 10) : $urandom_range(4, 10);
            rv.exp_valid = rv.stop_bit;
            rv.exp_fe    = !rv.stop_bit;
            apply_stimulus($sformatf("rand%0d", i), rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
